// File: rtl/fft_bf_sequencer_pkg.sv
// Shared definitions for the radix-2 DIT FFT butterfly sequencer: handshake
// state codes, butterfly k acknowledge points and default sizes.
package fft_pkg;

  localparam int N_LOG2_DEF = 11;
  localparam int DW_DEF     = 41;

  typedef enum logic [4:0] {
    ST_IDLE = 5'd0,
    ST_NEXT = 5'd8,
    ST_WAIT = 5'd9,
    ST_CAPB = 5'd10,
    ST_CAPA = 5'd11,
    ST_RDA  = 5'd12,
    ST_LDA  = 5'd13,
    ST_RDB  = 5'd14,
    ST_LDB  = 5'd15,
    ST_OUTA = 5'd16,
    ST_OUTB = 5'd17
  } fsm_state_e;

  // Butterfly step counter values the sequencer waits on
  localparam logic [3:0] K_IDLE   = 4'd0;
  localparam logic [3:0] K_A_DONE = 4'd2;
  localparam logic [3:0] K_B_DONE = 4'd5;
  localparam logic [3:0] K_CALC   = 4'd8;
  localparam logic [3:0] K_OUT_A  = 4'd9;

endpackage

// File: rtl/fft_bf_sequencer_if.sv
// Bundle between the FFT sequencer, sample RAM, twiddle ROM and butterfly.
// The err flag is present only when FFT_SEQ_WDOG_EN is defined.
interface fft_bf_sequencer_if
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int DW     = DW_DEF
);

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [N_LOG2-1:0]    mem_addr;
  logic                 mem_re;
  logic                 mem_we;
  logic signed [DW-1:0] mem_rdata_r;
  logic signed [DW-1:0] mem_rdata_i;
  logic signed [DW-1:0] mem_wdata_r;
  logic signed [DW-1:0] mem_wdata_i;
  logic [N_LOG2-2:0]    tw_addr;
  logic [4:0]           state;
  logic [3:0]           k;
  logic signed [DW-1:0] caldata_in_r;
  logic signed [DW-1:0] caldata_in_i;
  logic signed [DW-1:0] caldata_out_r;
  logic signed [DW-1:0] caldata_out_i;
`ifdef FFT_SEQ_WDOG_EN
  logic                 err;
`endif

  modport master (
    input  start, mem_rdata_r, mem_rdata_i, k, caldata_out_r, caldata_out_i,
    output busy, done, mem_addr, mem_re, mem_we, mem_wdata_r, mem_wdata_i,
           tw_addr, state, caldata_in_r, caldata_in_i
`ifdef FFT_SEQ_WDOG_EN
    , output err
`endif
  );

  modport slave (
    output start, mem_rdata_r, mem_rdata_i, k, caldata_out_r, caldata_out_i,
    input  busy, done, mem_addr, mem_re, mem_we, mem_wdata_r, mem_wdata_i,
           tw_addr, state, caldata_in_r, caldata_in_i
`ifdef FFT_SEQ_WDOG_EN
    , input err
`endif
  );

endinterface

// File: rtl/fft_bf_sequencer_addr_gen.sv
// Stage/butterfly counters and in-place operand addressing: a, b and the
// twiddle index for butterfly m of stage s, plus the wrap flags.
module fft_addr_gen #(
  parameter int N_LOG2 = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              step_i,
  output logic [N_LOG2-1:0] a_o,
  output logic [N_LOG2-1:0] b_o,
  output logic [N_LOG2-2:0] tw_addr_o,
  output logic              m_wrap_o,
  output logic              last_o
);

  localparam int              SW     = $clog2(N_LOG2);
  localparam logic [SW-1:0]   S_LAST = SW'(N_LOG2 - 1);

  logic [SW-1:0]     s_q, s_d;
  logic [N_LOG2-2:0] m_q, m_d;
  logic [N_LOG2-1:0] m_ext, mask, j;

  // a = g*2^(s+1) + j with g = m >> s, j = m mod 2^s; b sets bit s of a
  always_comb begin
    m_ext     = {1'b0, m_q};
    mask      = (N_LOG2'(1) << s_q) - N_LOG2'(1);
    j         = m_ext & mask;
    a_o       = ((m_ext & ~mask) << 1) | j;
    b_o       = a_o | (N_LOG2'(1) << s_q);
    tw_addr_o = j[N_LOG2-2:0] << (S_LAST - s_q);
  end

  assign m_wrap_o = &m_q;
  assign last_o   = m_wrap_o && (s_q == S_LAST);

  always_comb begin
    s_d = s_q;
    m_d = m_q;
    if (clr_i) begin
      s_d = '0;
      m_d = '0;
    end else if (step_i) begin
      m_d = m_q + 1'b1;
      if (m_wrap_o) s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      m_q <= '0;
    end else begin
      s_q <= s_d;
      m_q <= m_d;
    end
  end

endmodule

// File: rtl/fft_bf_sequencer.sv
// In-place radix-2 DIT FFT sequencer driving the butterfly through the state/k
// handshake. Define FFT_SEQ_WDOG_EN to add the acknowledge watchdog and err.
module fft_bf_sequencer
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int DW     = DW_DEF
) (
  input logic                 clk,
  input logic                 rst,
  fft_bf_sequencer_if.master  bus
);

  logic [4:0]           state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic signed [DW-1:0] cin_r_q, cin_r_d;
  logic signed [DW-1:0] cin_i_q, cin_i_d;
  logic                 cnt_clr, cnt_step;
  logic [N_LOG2-1:0]    addr_a, addr_b;
  logic [N_LOG2-2:0]    tw_idx;
  logic                 m_wrap, xform_last;
`ifdef FFT_SEQ_WDOG_EN
  logic [3:0]           wd_q, wd_d;
  logic                 err_q, err_d;
`endif

  fft_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (cnt_clr),
    .step_i    (cnt_step),
    .a_o       (addr_a),
    .b_o       (addr_b),
    .tw_addr_o (tw_idx),
    .m_wrap_o  (m_wrap),
    .last_o    (xform_last)
  );

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cin_r_d  = cin_r_q;
    cin_i_d  = cin_i_q;
    cnt_clr  = 1'b0;
    cnt_step = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        cnt_clr = 1'b1;
        busy_d  = 1'b1;
        state_d = ST_RDA;
      end
      ST_RDA:  state_d = ST_CAPA;
      ST_CAPA: begin
        cin_r_d = bus.mem_rdata_r;
        cin_i_d = bus.mem_rdata_i;
        state_d = ST_LDA;
      end
      ST_LDA:  if (bus.k == K_A_DONE) state_d = ST_RDB;
      ST_RDB:  state_d = ST_CAPB;
      ST_CAPB: begin
        cin_r_d = bus.mem_rdata_r;
        cin_i_d = bus.mem_rdata_i;
        state_d = ST_LDB;
      end
      ST_LDB:  if (bus.k == K_B_DONE) state_d = ST_WAIT;
      ST_WAIT: if (bus.k == K_CALC)   state_d = ST_OUTA;
      ST_OUTA: if (bus.k == K_OUT_A)  state_d = ST_OUTB;
      ST_OUTB: if (bus.k == K_IDLE)   state_d = ST_NEXT;
      ST_NEXT: begin
        cnt_step = 1'b1;
        if (xform_last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RDA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef FFT_SEQ_WDOG_EN
    // Any wait state still holding counts toward the timeout; 15 idle cycles abort
    wd_d  = '0;
    err_d = err_q;
    if ((state_q inside {ST_LDA, ST_LDB, ST_WAIT, ST_OUTA, ST_OUTB}) && (state_d == state_q)) begin
      if (wd_q == 4'hF) begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end else begin
        wd_d = wd_q + 4'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cin_r_q <= '0;
      cin_i_q <= '0;
`ifdef FFT_SEQ_WDOG_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cin_r_q <= cin_r_d;
      cin_i_q <= cin_i_d;
`ifdef FFT_SEQ_WDOG_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    case (state_q)
      ST_RDA, ST_OUTA: bus.mem_addr = addr_a;
      ST_RDB, ST_OUTB: bus.mem_addr = addr_b;
      default:         bus.mem_addr = '0;
    endcase
  end

  assign bus.state        = state_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mem_re       = (state_q == ST_RDA) || (state_q == ST_RDB);
  assign bus.mem_we       = ((state_q == ST_OUTA) && (bus.k == K_OUT_A)) ||
                            ((state_q == ST_OUTB) && (bus.k == K_IDLE));
  assign bus.mem_wdata_r  = bus.caldata_out_r;
  assign bus.mem_wdata_i  = bus.caldata_out_i;
  assign bus.tw_addr      = tw_idx;
  assign bus.caldata_in_r = cin_r_q;
  assign bus.caldata_in_i = cin_i_q;
`ifdef FFT_SEQ_WDOG_EN
  assign bus.err          = err_q;
`endif

endmodule

// File: tb/tb_fft_bf_sequencer.sv
// Directed bench for fft_bf_sequencer at N=8 with a behavioural butterfly,
// sample RAM and hand-computed expectations.
module tb_fft_bf_sequencer;
  import fft_pkg::*;

  localparam int NL  = 3;
  localparam int DWT = 41;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_bf_sequencer_if #(.N_LOG2(NL), .DW(DWT)) bus ();
  fft_bf_sequencer #(.N_LOG2(NL), .DW(DWT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Butterfly order for N=8: (a, b, tw) per butterfly
  int exp_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  // 127 * x[n-1] transformed: 127 * W8^k
  int exp_xr[8]  = '{127,  90,    0, -90, -127, -90,   0, 90};
  int exp_xi[8]  = '{  0, -90, -127, -90,    0,  90, 127, 90};

  // ---------------- behavioural butterfly ----------------
  logic [3:0]            k_q;
  logic                  k_stuck = 1'b0;
  logic signed [DWT-1:0] sa_r, sa_i, top_r, top_i, bot_r, bot_i;
  longint                br, bi, wr, wi, pr, pi;

  function automatic longint tw_re(input logic [1:0] t);
    case (t)
      2'd0: return 127;
      2'd1: return 90;
      2'd2: return 0;
      default: return -90;
    endcase
  endfunction

  function automatic longint tw_im(input logic [1:0] t);
    case (t)
      2'd0: return 0;
      2'd1: return -90;
      2'd2: return -127;
      default: return -90;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      k_q <= 4'd0;
    end else begin
      case (bus.state)
        ST_LDA: begin
          if (k_q == 4'd1) begin
            sa_r <= bus.caldata_in_r;
            sa_i <= bus.caldata_in_i;
          end
          if (k_q < 4'd2) k_q <= k_q + 4'd1;
        end
        ST_LDB: begin
          if (k_q == 4'd4) begin
            br = longint'(bus.caldata_in_r);
            bi = longint'(bus.caldata_in_i);
            wr = tw_re(bus.tw_addr);
            wi = tw_im(bus.tw_addr);
            pr = (br * wr - bi * wi) / 127;
            pi = (br * wi + bi * wr) / 127;
            top_r <= DWT'(longint'(sa_r) + pr);
            top_i <= DWT'(longint'(sa_i) + pi);
            bot_r <= DWT'(longint'(sa_r) - pr);
            bot_i <= DWT'(longint'(sa_i) - pi);
          end
          if (k_q <= 4'd5) k_q <= k_q + 4'd1;
        end
        ST_WAIT: if (k_q < 4'd8) k_q <= k_q + 4'd1;
        ST_OUTA: if (k_q < 4'd9) k_q <= k_q + 4'd1;
        ST_OUTB: if (k_q == 4'd9) k_q <= 4'd0;
        default: ;
      endcase
    end
  end

  assign bus.k             = k_stuck ? 4'd1 : k_q;
  assign bus.caldata_out_r = (bus.state == ST_OUTA) ? top_r : bot_r;
  assign bus.caldata_out_i = (bus.state == ST_OUTA) ? top_i : bot_i;

  // ---------------- sample RAM ----------------
  logic signed [DWT-1:0] ram_r [8];
  logic signed [DWT-1:0] ram_i [8];
  logic signed [DWT-1:0] ld_r  [8];
  logic signed [DWT-1:0] ld_i  [8];
  logic signed [DWT-1:0] rd_r = '0, rd_i = '0;
  logic                  ram_load = 1'b0;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 8; i++) begin
        ram_r[i] = ld_r[i];
        ram_i[i] = ld_i[i];
      end
    end else if (bus.mem_we) begin
      ram_r[bus.mem_addr] = bus.mem_wdata_r;
      ram_i[bus.mem_addr] = bus.mem_wdata_i;
    end
    if (bus.mem_re) begin
      rd_r <= ram_r[bus.mem_addr];
      rd_i <= ram_i[bus.mem_addr];
    end
  end

  assign bus.mem_rdata_r = rd_r;
  assign bus.mem_rdata_i = rd_i;

  // ---------------- monitor ----------------
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic mon_clr = 1'b0;
  int   bf_cnt, wr_cnt, overlap, tw_err, done_cnt, t_rda, t_lda, t_done, t_err;
  int   rda_addr [64];
  int   rdb_addr [64];
  int   tw_log   [64];
  int   wr_addr  [64];

  always @(negedge clk) begin
    if (mon_clr) begin
      bf_cnt = 0; wr_cnt = 0; overlap = 0; tw_err = 0; done_cnt = 0;
      t_rda = -1; t_lda = -1; t_done = -1; t_err = -1;
    end else begin
      if (bus.mem_re && bus.mem_we) overlap++;
      if (bus.state == ST_RDA) begin
        if (t_rda < 0) t_rda = cyc;
        rda_addr[bf_cnt & 63] = int'(bus.mem_addr);
        tw_log[bf_cnt & 63]   = int'(bus.tw_addr);
      end else if (bus.state != ST_IDLE && int'(bus.tw_addr) != tw_log[bf_cnt & 63]) begin
        tw_err++;
      end
      if (bus.state == ST_RDB) rdb_addr[bf_cnt & 63] = int'(bus.mem_addr);
      if (bus.state == ST_LDA && t_lda < 0) t_lda = cyc;
      if (bus.mem_we) begin
        wr_addr[wr_cnt & 63] = int'(bus.mem_addr);
        wr_cnt++;
      end
      if (bus.state == ST_NEXT) bf_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (t_done < 0) t_done = cyc;
      end
`ifdef FFT_SEQ_WDOG_EN
      if (bus.err && t_err < 0) t_err = cyc;
`endif
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic load_ram(input int pos, input int vr);
    for (int i = 0; i < 8; i++) begin
      ld_r[i] = '0;
      ld_i[i] = '0;
    end
    ld_r[pos] = DWT'(vr);
    ram_load = 1'b1;
    tick();
    ram_load = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", (done_cnt > 0) ? 1 : 0, 1);
    repeat (3) tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int found;
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_state",    bus.state,        ST_IDLE);
    check("rst_busy",     bus.busy,         0);
    check("rst_done",     bus.done,         0);
    check("rst_mem_re",   bus.mem_re,       0);
    check("rst_mem_we",   bus.mem_we,       0);
    check("rst_mem_addr", bus.mem_addr,     0);
    check("rst_tw_addr",  bus.tw_addr,      0);
    check("rst_cin_r",    bus.caldata_in_r, 0);
    check("rst_cin_i",    bus.caldata_in_i, 0);
`ifdef FFT_SEQ_WDOG_EN
    check("rst_err",      bus.err,          0);
`endif
    rst = 1'b0;
    tick();

    // Shifted impulse x[1]=127, bit-reversed to position 4
    load_ram(4, 127);
    clear_mon();
    pulse_start();
    check("start_state", bus.state, ST_RDA);
    check("start_busy",  bus.busy,  1);
    wait_done(400);
    check("run1_cycles",   t_done - t_rda, 228);
    check("run1_bflies",   bf_cnt,         12);
    check("run1_writes",   wr_cnt,         24);
    check("run1_re_we",    overlap,        0);
    check("run1_tw_held",  tw_err,         0);
    check("run1_done_one", done_cnt,       1);
    check("run1_busy_end", bus.busy,       0);
    check("run1_idle_end", bus.state,      ST_IDLE);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("rd_a[%0d]", i), rda_addr[i],    exp_a[i]);
      check($sformatf("rd_b[%0d]", i), rdb_addr[i],    exp_b[i]);
      check($sformatf("tw[%0d]", i),   tw_log[i],      exp_tw[i]);
      check($sformatf("wr_a[%0d]", i), wr_addr[2*i],   exp_a[i]);
      check($sformatf("wr_b[%0d]", i), wr_addr[2*i+1], exp_b[i]);
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("x1_r[%0d]", i), ram_r[i], exp_xr[i]);
      check($sformatf("x1_i[%0d]", i), ram_i[i], exp_xi[i]);
    end

    // Abort during OUTA of butterfly 5
    load_ram(0, 1);
    clear_mon();
    pulse_start();
    found = 0;
    for (int n = 0; n < 400 && found == 0; n++) begin
      if (bf_cnt == 5 && bus.state == ST_OUTA) found = 1;
      else tick();
    end
    check("abort_reach", found, 1);
    rst = 1'b1;
    tick();
    check("abort_state",  bus.state,  ST_IDLE);
    check("abort_busy",   bus.busy,   0);
    check("abort_mem_we", bus.mem_we, 0);
    rst = 1'b0;
    repeat (5) tick();
    check("abort_writes", wr_cnt, 10);

    // Fresh impulse run with a start re-pulse while busy
    load_ram(0, 1);
    clear_mon();
    pulse_start();
    repeat (40) tick();
    pulse_start();
    wait_done(400);
    check("run3_cycles",   t_done - t_rda, 228);
    check("run3_bflies",   bf_cnt,         12);
    check("run3_writes",   wr_cnt,         24);
    check("run3_done_one", done_cnt,       1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("imp_r[%0d]", i), ram_r[i], 1);
      check($sformatf("imp_i[%0d]", i), ram_i[i], 0);
    end

`ifdef FFT_SEQ_WDOG_EN
    // Butterfly never acknowledges: k held at 1
    k_stuck = 1'b1;
    clear_mon();
    pulse_start();
    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      if (bus.err === 1'b1) found = 1;
      else tick();
    end
    check("wd_err_set",   found,         1);
    check("wd_err_delay", t_err - t_lda, 16);
    check("wd_busy",      bus.busy,      0);
    check("wd_state",     bus.state,     ST_IDLE);
    repeat (20) tick();
    check("wd_no_done",   done_cnt,      0);
    check("wd_sticky",    bus.err,       1);
    k_stuck = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
